// File: rtl/bmp280_temp_comp.sv
// BMP280 temperature compensation: adc_T + dig_T1..T3 -> temp (0.01 degC) and t_fine,
// using one shared 32x32 signed multiplier. Optional output clamp: BMP280_TEMP_CLAMP_EN.
module bmp280_temp_comp (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [19:0]        raw_temp,
  input  logic               raw_valid,
  input  logic [15:0]        dig_T1,
  input  logic [15:0]        dig_T2,
  input  logic [15:0]        dig_T3,
  output logic               busy,
  output logic signed [31:0] temp,
  output logic signed [31:0] t_fine,
  output logic               temp_valid,
  output logic               temp_err
);

  typedef enum logic [2:0] {
    IDLE, DIFF, MUL1, MUL2, MUL3, SUM, OUT
  } state_t;

  state_t state, state_next;

  logic [19:0]        raw_q;
  logic signed [31:0] a_q, b_q, var1_q, sq_q, var2_q, tf_next_q;

  logic signed [31:0] adc_s, t1_s, t2_s, t3_s;
  logic signed [31:0] a_d, b_d;
  logic signed [31:0] mul_a, mul_b, mul_res;
  logic signed [63:0] mul_a_ext, mul_b_ext, prod;
  logic signed [31:0] temp_raw, temp_sat;
  logic               accept, skip;

  // The strobe cycle still counts as busy, so a sample arriving there is dropped.
  assign accept = (state == IDLE) && raw_valid && !temp_valid;
  assign skip   = (raw_q == 20'h80000);
  assign busy   = (state != IDLE) || temp_valid;

  assign adc_s = signed'({12'd0, raw_q});
  assign t1_s  = signed'({16'd0, dig_T1});
  assign t2_s  = signed'({{16{dig_T2[15]}}, dig_T2});
  assign t3_s  = signed'({{16{dig_T3[15]}}, dig_T3});

  assign a_d = (adc_s >>> 3) - (t1_s <<< 1);
  assign b_d = (adc_s >>> 4) - t1_s;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mul_a = a_q;
    mul_b = t2_s;
    case (state)
      MUL2: begin
        mul_a = b_q;
        mul_b = b_q;
      end
      MUL3: begin
        mul_a = sq_q;
        mul_b = t3_s;
      end
      default: ;
    endcase
  end

  assign mul_a_ext = mul_a;
  assign mul_b_ext = mul_b;
  assign prod      = mul_a_ext * mul_b_ext;

  // Shift the full 64-bit product, then truncate: matches the int32 datasheet reference.
  always_comb begin
    mul_res = 32'(prod >>> 11);
    case (state)
      MUL2:    mul_res = 32'(prod >>> 12);
      MUL3:    mul_res = 32'(prod >>> 14);
      default: ;
    endcase
  end

  assign temp_raw = ((tf_next_q * 32'sd5) + 32'sd128) >>> 8;

`ifdef BMP280_TEMP_CLAMP_EN
  always_comb begin
    temp_sat = temp_raw;
    if (temp_raw < -32'sd4000)
      temp_sat = -32'sd4000;
    else if (temp_raw > 32'sd8500)
      temp_sat = 32'sd8500;
  end
`else
  assign temp_sat = temp_raw;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DIFF;
      DIFF:    state_next = skip ? OUT : MUL1;
      MUL1:    state_next = MUL2;
      MUL2:    state_next = MUL3;
      MUL3:    state_next = SUM;
      SUM:     state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: datapath pipeline registers carry no reset; each is written before it is read.
  always_ff @(posedge clk) begin
    if (accept)
      raw_q <= raw_temp;
    case (state)
      DIFF: begin
        a_q <= a_d;
        b_q <= b_d;
      end
      MUL1:    var1_q    <= mul_res;
      MUL2:    sq_q      <= mul_res;
      MUL3:    var2_q    <= mul_res;
      SUM:     tf_next_q <= var1_q + var2_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp       <= '0;
      t_fine     <= '0;
      temp_valid <= 1'b0;
      temp_err   <= 1'b0;
    end else begin
      temp_valid <= (state == OUT);
      if (state == OUT) begin
        temp_err <= skip;
        if (!skip) begin
          temp   <= temp_sat;
          t_fine <= tf_next_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmp280_temp_comp.sv
// Scoreboard bench for bmp280_temp_comp: directed datasheet/skip/ignore/reset cases plus a
// random sweep against an integer model of the datasheet compensation formula.
module tb_bmp280_temp_comp;

  logic               clk;
  logic               rst_n;
  logic [19:0]        raw_temp;
  logic               raw_valid;
  logic [15:0]        dig_T1, dig_T2, dig_T3;
  logic               busy;
  logic signed [31:0] temp, t_fine;
  logic               temp_valid, temp_err;

  bmp280_temp_comp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_temp   (raw_temp),
    .raw_valid  (raw_valid),
    .dig_T1     (dig_T1),
    .dig_T2     (dig_T2),
    .dig_T3     (dig_T3),
    .busy       (busy),
    .temp       (temp),
    .t_fine     (t_fine),
    .temp_valid (temp_valid),
    .temp_err   (temp_err)
  );

  typedef struct {
    int temp;
    int tf;
    bit err;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   prev_temp = 0;
  int   prev_tf   = 0;
  int   hold_temp = 0;
  int   hold_tf   = 0;
  bit   hold_err  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at t=%0t",
               name, $signed(act), act, $signed(exp), exp, $time);
    end
  endtask

  // Datasheet int32 formula; 64-bit intermediate products, truncated back to int.
  function automatic void model(input logic [19:0] r, input logic [15:0] t1, input logic [15:0] t2,
                                input logic [15:0] t3, output int tf, output int tc);
    longint adc, d1, d2, d3, a, b;
    int     var1, sq, var2;
    adc  = longint'(r);
    d1   = longint'(t1);
    d2   = longint'($signed(t2));
    d3   = longint'($signed(t3));
    a    = (adc / 8) - 2 * d1;
    b    = (adc / 16) - d1;
    var1 = int'((a * d2) >>> 11);
    sq   = int'((b * b) >>> 12);
    var2 = int'((longint'(sq) * d3) >>> 14);
    tf   = var1 + var2;
    tc   = (tf * 5 + 128) >>> 8;
`ifdef BMP280_TEMP_CLAMP_EN
    if (tc < -4000) tc = -4000;
    if (tc > 8500)  tc = 8500;
`endif
  endfunction

  function automatic exp_t expect_for(input logic [19:0] r, input logic [15:0] t1,
                                      input logic [15:0] t2, input logic [15:0] t3);
    exp_t e;
    int   tf, tc;
    if (r == 20'h80000) begin
      e.temp = prev_temp;
      e.tf   = prev_tf;
      e.err  = 1'b1;
      e.lat  = 2;
    end else begin
      model(r, t1, t2, t3, tf, tc);
      e.temp = tc;
      e.tf   = tf;
      e.err  = 1'b0;
      e.lat  = 6;
    end
    return e;
  endfunction

  // Entered just after a rising edge; leaves just after the edge where the DUT is idle again.
  task automatic send(input logic [19:0] r, input logic [15:0] t1, input logic [15:0] t2,
                      input logic [15:0] t3, input int gap);
    exp_t e;
    raw_temp  = r;
    dig_T1    = t1;
    dig_T2    = t2;
    dig_T3    = t3;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
    e = expect_for(r, t1, t2, t3);
    e.acc = cyc;
    if (!e.err) begin
      prev_temp = e.temp;
      prev_tf   = e.tf;
    end
    sb.push_back(e);
    repeat ((e.err ? 3 : 7) + gap) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per strobe, otherwise checks that outputs hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_temp = 0;
      hold_tf   = 0;
      hold_err  = 1'b0;
    end else if (temp_valid) begin
      if (sb.size() == 0) begin
        check("spurious_temp_valid", 32'(temp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("temp", temp, e.temp);
        check("t_fine", t_fine, e.tf);
        check("temp_err", 32'(temp_err), 32'(e.err));
        check("latency", cyc - e.acc, e.lat);
        check("busy_at_valid", 32'(busy), 32'd1);
        hold_temp = e.temp;
        hold_tf   = e.tf;
        hold_err  = e.err;
      end
    end else begin
      check("temp_hold", temp, hold_temp);
      check("t_fine_hold", t_fine, hold_tf);
      check("temp_err_hold", 32'(temp_err), 32'(hold_err));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cold;
    rst_n     = 1'b0;
    raw_valid = 1'b0;
    raw_temp  = '0;
    dig_T1    = '0;
    dig_T2    = '0;
    dig_T3    = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_temp", temp, 32'd0);
    check("rst_t_fine", t_fine, 32'd0);
    check("rst_temp_valid", 32'(temp_valid), 32'd0);
    check("rst_temp_err", 32'(temp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Datasheet vector, then the skipped code, then adc_T=0.
    send(20'd519888, 16'd27504, 16'd26435, 16'hFC18, 0);
    check("ds_prev_temp", 32'(prev_temp), 32'd2508);
    check("ds_prev_tf", 32'(prev_tf), 32'd128422);
    send(20'h80000, 16'd27504, 16'd26435, 16'hFC18, 0);
    send(20'd0, 16'd27504, 16'd26435, 16'hFC18, 1);
`ifdef BMP280_TEMP_CLAMP_EN
    exp_cold = -4000;
`else
    exp_cold = -14088;
`endif
    check("cold_temp_model", 32'(prev_temp), 32'(exp_cold));
    check("cold_tf_model", 32'(prev_tf), 32'(-721301));

    // raw_valid at accept+2 and during the strobe cycle must both be ignored.
    begin
      exp_t e;
      raw_temp  = 20'd519888;
      raw_valid = 1'b1;
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
      e = expect_for(20'd519888, 16'd27504, 16'd26435, 16'hFC18);
      e.acc = cyc;
      prev_temp = e.temp;
      prev_tf   = e.tf;
      sb.push_back(e);
      check("busy_after_accept", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      raw_temp  = 20'd400000;
      raw_valid = 1'b1;
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
      raw_temp  = 20'd519888;
      repeat (4) @(posedge clk);
      #1;
      check("strobe_cycle", 32'(temp_valid), 32'd1);
      raw_temp  = 20'd400000;
      raw_valid = 1'b1;
      @(posedge clk);
      #1;
      raw_valid = 1'b0;
      check("busy_after_ignored", 32'(busy), 32'd0);
      send(20'd300000, 16'd27504, 16'd26435, 16'hFC18, 0);
    end

    // Asynchronous reset while the FSM sits in MUL2.
    raw_temp  = 20'd519888;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_temp", temp, 32'd0);
    check("midrst_t_fine", t_fine, 32'd0);
    check("midrst_temp_valid", 32'(temp_valid), 32'd0);
    sb.delete();
    prev_temp = 0;
    prev_tf   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    send(20'h80000, 16'd27504, 16'd26435, 16'hFC18, 0);
    send(20'd519888, 16'd27504, 16'd26435, 16'hFC18, 0);

    // Random sweep with forced corner values.
    for (int i = 0; i < 1000; i++) begin
      logic [19:0] r;
      logic [15:0] t1, t2, t3;
      r  = 20'($urandom);
      t1 = 16'($urandom);
      t2 = 16'($urandom);
      t3 = 16'($urandom);
      if (i % 50 == 0) r  = 20'hFFFFF;
      if (i % 50 == 1) t1 = 16'hFFFF;
      if (i % 50 == 2) begin
        r  = 20'hFFFFF;
        t1 = 16'hFFFF;
      end
      if (i % 97 == 5) r = 20'h80000;
      send(r, t1, t2, t3, int'($urandom_range(0, 2)));
    end

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
